uart_tx_param: RTL

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_cnt.sv | 34 +++
 rtl/uart_tx_param.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-mode encodings,
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } parity_mode_e;

    localparam int unsigned LEN_MIN = 5;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: tick marks the last clock of each bit period and
// the counter reloads itself on every tick or on an explicit load.
module uart_baud_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] reload_s;

    // A divisor of zero behaves like one: the count starts already at zero.
    always_comb begin
        reload_s = (div == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : (div - {{(DIV_W-1){1'b0}}, 1'b1});
    end

    // Down-count, reloading at each bit boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (load || (cnt_r == {DIV_W{1'b0}})) begin
            cnt_r <= reload_s;
        end else begin
            cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    assign tick = (cnt_r == {DIV_W{1'b0}});

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: configurable data length, parity, stop bits
// and bit order, all captured at frame acceptance.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_MAX = 9,
    parameter int DIV_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [DATA_MAX-1:0] tx_data,
    input  logic [3:0]          frame_length,
    input  logic                parity_en,
    input  logic [1:0]          parity_mode,
    input  logic                stop_bits,
    input  logic                msb_first,
    input  logic [DIV_W-1:0]    baud_div,
    output logic                tx,
    output logic                busy,
    output logic                done
);

    localparam logic [4:0] LEN_MIN_L = 5'(LEN_MIN);
    localparam logic [4:0] LEN_MAX_L = 5'(DATA_MAX);

    // Parity over the first len bits only; bits beyond the frame are ignored.
    function automatic logic parity_calc(input logic [DATA_MAX-1:0] data,
                                         input logic [4:0]          len,
                                         input logic [1:0]          mode);
        logic x;
        logic p;
        x = 1'b0;
        for (int i = 0; i < DATA_MAX; i++) begin
            x = x ^ (data[i] & (5'(i) < len));
        end
        case (mode)
            PAR_EVEN:  p = x;
            PAR_ODD:   p = ~x;
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b0;
        endcase
        return p;
    endfunction

    function automatic logic data_bit(input logic [DATA_MAX-1:0] data,
                                      input logic [4:0]          pos);
        logic b;
        b = 1'b0;
        for (int i = 0; i < DATA_MAX; i++) begin
            b = b | (data[i] & (5'(i) == pos));
        end
        return b;
    endfunction

    uart_state_e         state_r;
    logic                tx_r;
    logic                busy_r;
    logic                done_r;
    logic                ready_r;
    logic [DATA_MAX-1:0] data_r;
    logic [4:0]          len_r;
    logic                par_en_r;
    logic [1:0]          par_mode_r;
    logic                stop_two_r;
    logic                msb_r;
    logic [DIV_W-1:0]    div_r;
    logic [3:0]          bit_idx_r;
    logic                stop_second_r;

    logic                accept_s;
    logic                tick_s;
    logic [DIV_W-1:0]    div_sel_s;
    logic [4:0]          len_clamp_s;
    logic [3:0]          nxt_idx_s;
    logic [4:0]          pos_s;
    logic                nxt_bit_s;
    logic                last_bit_s;

    // Acceptance, length clamp and next-data-bit selection.
    always_comb begin
        accept_s    = tx_valid && ready_r && (state_r == ST_IDLE);
        div_sel_s   = accept_s ? baud_div : div_r;
        len_clamp_s = ({1'b0, frame_length} < LEN_MIN_L) ? LEN_MIN_L :
                      (({1'b0, frame_length} > LEN_MAX_L) ? LEN_MAX_L : {1'b0, frame_length});
        nxt_idx_s   = (state_r == ST_DATA) ? (bit_idx_r + 4'd1) : 4'd0;
        pos_s       = msb_r ? (len_r - 5'd1 - {1'b0, nxt_idx_s}) : {1'b0, nxt_idx_s};
        nxt_bit_s   = data_bit(data_r, pos_s);
        last_bit_s  = ({1'b0, bit_idx_r} == (len_r - 5'd1));
    end

    uart_baud_cnt #(
        .DIV_W (DIV_W)
    ) u_baud_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (accept_s),
        .div  (div_sel_s),
        .tick (tick_s)
    );

    // Frame sequencer with registered line and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            tx_r          <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            ready_r       <= 1'b0;
            data_r        <= {DATA_MAX{1'b0}};
            len_r         <= 5'd0;
            par_en_r      <= 1'b0;
            par_mode_r    <= 2'b00;
            stop_two_r    <= 1'b0;
            msb_r         <= 1'b0;
            div_r         <= {DIV_W{1'b0}};
            bit_idx_r     <= 4'd0;
            stop_second_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tx_r <= 1'b1;
                    if (accept_s) begin
                        data_r     <= tx_data;
                        len_r      <= len_clamp_s;
                        par_en_r   <= parity_en;
                        par_mode_r <= parity_mode;
                        stop_two_r <= stop_bits;
                        msb_r      <= msb_first;
                        div_r      <= baud_div;
                        state_r    <= ST_START;
                        tx_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        ready_r    <= 1'b0;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        state_r   <= ST_DATA;
                        bit_idx_r <= 4'd0;
                        tx_r      <= nxt_bit_s;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (!last_bit_s) begin
                            bit_idx_r <= nxt_idx_s;
                            tx_r      <= nxt_bit_s;
                        end else if (par_en_r) begin
                            state_r <= ST_PARITY;
                            tx_r    <= parity_calc(data_r, len_r, par_mode_r);
                        end else begin
                            state_r       <= ST_STOP;
                            tx_r          <= 1'b1;
                            stop_second_r <= 1'b0;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick_s) begin
                        state_r       <= ST_STOP;
                        tx_r          <= 1'b1;
                        stop_second_r <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        if (stop_two_r && !stop_second_r) begin
                            stop_second_r <= 1'b1;
                        end else begin
                            state_r       <= ST_IDLE;
                            done_r        <= 1'b1;
                            busy_r        <= 1'b0;
                            ready_r       <= 1'b1;
                            tx_r          <= 1'b1;
                            stop_second_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign tx_ready = ready_r;

endmodule
